// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the data-memory port arbiter.
// Holds the sequencer state encoding, access size codes, the default
// data-segment window and small helpers used by the arbiter and its bench.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_DONE   = 2'b10,
    ST_FAULT  = 2'b11
  } arb_state_e;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam logic [31:0] DEF_BASE_ADDR = 32'h1001_0000;
  localparam logic [31:0] DEF_MEM_BYTES = 32'h0000_1000;

  // True when the size code is reserved or the address is not naturally
  // aligned for the requested size.
  function automatic logic bad_shape(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SZ_WORD: bad = (addr_lo != 2'b00);
      SZ_HALF: bad = addr_lo[0];
      SZ_BYTE: bad = 1'b0;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // One-hot acknowledge vector for the winning master index.
  function automatic logic [1:0] grant_onehot(input logic winner);
    logic [1:0] oh;
    if (winner) begin
      oh = 2'b10;
    end else begin
      oh = 2'b01;
    end
    return oh;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two masters, the arbiter and the data memory.
// The slave modport is the arbiter's view; the master modport is the view
// of the environment that owns the requesters and the memory.
interface mem_port_arbiter_if;

  logic [1:0]  req;
  logic [1:0]  we;
  logic [1:0]  size0;
  logic [1:0]  size1;
  logic [1:0]  sign;
  logic [31:0] addr0;
  logic [31:0] addr1;
  logic [31:0] wdata0;
  logic [31:0] wdata1;
  logic [31:0] rdata;
  logic [1:0]  ack;
  logic        fault;
  logic        mem_w;
  logic        mem_r;
  logic [1:0]  mem_c;
  logic        mem_s;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  req, we, size0, size1, sign, addr0, addr1, wdata0, wdata1, mem_rdata,
    output rdata, ack, fault, mem_w, mem_r, mem_c, mem_s, mem_addr, mem_wdata
  );

  modport master (
    output req, we, size0, size1, sign, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  rdata, ack, fault, mem_w, mem_r, mem_c, mem_s, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_port_arbiter_pick.sv
// Combinational winner selection for the two-master memory port.
// Build option MEM_ARB_RR_EN: when defined, simultaneous requests go to the
// master that was not granted last (last_grant port exists); otherwise the
// CPU (master 0) always wins a tie and no pointer input is present.
module mem_arb_pick (
  input  logic [1:0] req,
  output logic       winner
`ifdef MEM_ARB_RR_EN
  ,
  input  logic       last_grant
`endif
);

`ifdef MEM_ARB_RR_EN
  // Round-robin choice: on a tie favour the master not granted last.
  always_comb begin
    winner = 1'b0;
    if (req == 2'b11) begin
      winner = ~last_grant;
    end else if (req[1]) begin
      winner = 1'b1;
    end else begin
      winner = 1'b0;
    end
  end
`else
  // Fixed priority: the CPU wins whenever it requests.
  always_comb begin
    winner = 1'b0;
    if (req[0]) begin
      winner = 1'b0;
    end else if (req[1]) begin
      winner = 1'b1;
    end else begin
      winner = 1'b0;
    end
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-master arbiter and sequencer for the single data-memory port.
// Serialises CPU/loader accesses, rebases addresses onto the data segment,
// rejects out-of-window, misaligned or reserved-size requests, and holds the
// memory strobes for WAIT_CYCLES+1 cycles before a one-cycle acknowledge.
// Build option MEM_ARB_RR_EN selects round-robin arbitration and builds the
// last-grant pointer; without it the CPU has fixed priority.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
  parameter logic [31:0] MEM_BYTES   = DEF_MEM_BYTES,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  arb_state_e  state_r, state_s;
  logic [3:0]  cnt_r, cnt_s;
  logic        winner_r, winner_s;
  logic        we_r, we_s;
  logic [1:0]  size_r, size_s;
  logic        sign_r, sign_s;
  logic [31:0] offset_r, offset_s;
  logic [31:0] wdata_r, wdata_s;
  logic        mem_w_r, mem_w_s;
  logic        mem_r_r, mem_r_s;
  logic [1:0]  ack_r, ack_s;
  logic        fault_r, fault_s;
  logic [31:0] rdata_r, rdata_s;

  logic        pick_s;
  logic        sel_we_s;
  logic [1:0]  sel_size_s;
  logic        sel_sign_s;
  logic [31:0] sel_addr_s;
  logic [31:0] sel_wdata_s;
  logic [31:0] sel_offset_s;
  logic        reject_s;

`ifdef MEM_ARB_RR_EN
  logic        last_r, last_s;
`endif

  mem_arb_pick u_pick (
    .req        (bus.req),
    .winner     (pick_s)
`ifdef MEM_ARB_RR_EN
    ,
    .last_grant (last_r)
`endif
  );

  // Route the candidate winner's request fields and judge whether it is legal.
  always_comb begin
    sel_we_s     = pick_s ? bus.we[1]   : bus.we[0];
    sel_size_s   = pick_s ? bus.size1   : bus.size0;
    sel_sign_s   = pick_s ? bus.sign[1] : bus.sign[0];
    sel_addr_s   = pick_s ? bus.addr1   : bus.addr0;
    sel_wdata_s  = pick_s ? bus.wdata1  : bus.wdata0;
    // Addresses below the base wrap to huge offsets and fail the range test.
    sel_offset_s = sel_addr_s - BASE_ADDR;
    reject_s     = (sel_offset_s >= MEM_BYTES) | bad_shape(sel_size_s, sel_addr_s[1:0]);
  end

  // Sequencer next-state and next values of every registered output.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    winner_s = winner_r;
    we_s     = we_r;
    size_s   = size_r;
    sign_s   = sign_r;
    offset_s = offset_r;
    wdata_s  = wdata_r;
    mem_w_s  = 1'b0;
    mem_r_s  = 1'b0;
    ack_s    = 2'b00;
    fault_s  = 1'b0;
    rdata_s  = 32'h0000_0000;
`ifdef MEM_ARB_RR_EN
    last_s   = last_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (|bus.req) begin
          winner_s = pick_s;
          we_s     = sel_we_s;
          size_s   = sel_size_s;
          sign_s   = sel_sign_s;
          offset_s = sel_offset_s;
          wdata_s  = sel_wdata_s;
`ifdef MEM_ARB_RR_EN
          last_s   = pick_s;
`endif
          if (reject_s) begin
            state_s = ST_FAULT;
            ack_s   = grant_onehot(pick_s);
            fault_s = 1'b1;
          end else begin
            state_s = ST_ACCESS;
            cnt_s   = WAIT_INIT;
            mem_w_s = sel_we_s;
            mem_r_s = ~sel_we_s;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (cnt_r == 4'd0) begin
          // Last strobe cycle: capture the load data and acknowledge next.
          state_s = ST_DONE;
          ack_s   = grant_onehot(winner_r);
          rdata_s = we_r ? 32'h0000_0000 : bus.mem_rdata;
        end else begin
          cnt_s   = cnt_r - 4'd1;
          mem_w_s = we_r;
          mem_r_s = ~we_r;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      ST_FAULT: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, latched request fields and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= ST_IDLE;
      cnt_r    <= 4'd0;
      winner_r <= 1'b0;
      we_r     <= 1'b0;
      size_r   <= 2'b00;
      sign_r   <= 1'b0;
      offset_r <= 32'h0000_0000;
      wdata_r  <= 32'h0000_0000;
      mem_w_r  <= 1'b0;
      mem_r_r  <= 1'b0;
      ack_r    <= 2'b00;
      fault_r  <= 1'b0;
      rdata_r  <= 32'h0000_0000;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      winner_r <= winner_s;
      we_r     <= we_s;
      size_r   <= size_s;
      sign_r   <= sign_s;
      offset_r <= offset_s;
      wdata_r  <= wdata_s;
      mem_w_r  <= mem_w_s;
      mem_r_r  <= mem_r_s;
      ack_r    <= ack_s;
      fault_r  <= fault_s;
      rdata_r  <= rdata_s;
    end
  end

`ifdef MEM_ARB_RR_EN
  // Last-grant pointer; reset value makes master 0 win the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_r <= 1'b1;
    end else begin
      last_r <= last_s;
    end
  end
`endif

  assign bus.mem_w     = mem_w_r;
  assign bus.mem_r     = mem_r_r;
  assign bus.mem_c     = size_r;
  assign bus.mem_s     = sign_r;
  assign bus.mem_addr  = offset_r;
  assign bus.mem_wdata = wdata_r;
  assign bus.ack       = ack_r;
  assign bus.fault     = fault_r;
  assign bus.rdata     = rdata_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, hand
// sequences for hold/tie/reset corners, and randomized traffic compared with
// a transaction-level model of the arbitration and access rules.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int          WAIT = 3;
  localparam logic [31:0] BASE = 32'h1001_0000;
  localparam logic [31:0] MEMB = 32'h0000_1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.BASE_ADDR(BASE), .MEM_BYTES(MEMB), .WAIT_CYCLES(WAIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  logic        f_we[2];
  logic [1:0]  f_size[2];
  logic        f_sign[2];
  logic [31:0] f_addr[2];
  logic [31:0] f_wdata[2];
  logic        model_last;

  // Memory content as seen at the port: a fixed word at 0x10, a pattern elsewhere.
  function automatic logic [31:0] mem_model(input logic [31:0] off);
    if (off == 32'h0000_0010) return 32'hDEAD_BEEF;
    return {off[15:0] ^ 16'hA5C3, ~off[15:0]};
  endfunction

  always_comb bus.mem_rdata = mem_model(bus.mem_addr);

  // Request acceptance rule: window, reserved size, natural alignment.
  function automatic bit model_reject(input logic [31:0] addr, input logic [1:0] size);
    longint unsigned off;
    off = (longint'(addr) - longint'(BASE)) & 64'hFFFF_FFFF;
    if (off >= longint'(MEMB)) return 1'b1;
    if (size == 2'd3) return 1'b1;
    if (size == 2'd0 && (addr % 4) != 0) return 1'b1;
    if (size == 2'd1 && (addr % 2) != 0) return 1'b1;
    return 1'b0;
  endfunction

  // Which requester the model expects to be served next.
  function automatic int model_pick(input logic [1:0] mask);
    if (mask == 2'b01) return 0;
    if (mask == 2'b10) return 1;
`ifdef MEM_ARB_RR_EN
    return (model_last == 1'b1) ? 0 : 1;
`else
    return 0;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_fields();
    bus.we     = {f_we[1], f_we[0]};
    bus.size0  = f_size[0];
    bus.size1  = f_size[1];
    bus.sign   = {f_sign[1], f_sign[0]};
    bus.addr0  = f_addr[0];
    bus.addr1  = f_addr[1];
    bus.wdata0 = f_wdata[0];
    bus.wdata1 = f_wdata[1];
  endtask

  // Issue requests from the masters in mask (called in an IDLE cycle) and
  // check each acknowledge; returns the fault flag of the last ack seen.
  task automatic run_txn(input logic [1:0] mask, input string name, output logic obs_fault);
    logic [1:0]  pending;
    logic [31:0] exp_off;
    int w, start, cyc, strobes;
    bit shape_bad, done, flt;
    pending = mask; start = 0; cyc = 0; strobes = 0; shape_bad = 1'b0; done = 1'b0;
    obs_fault = 1'b0;
    drive_fields();
    bus.req = mask;
    w = model_pick(pending);
    while (!done) begin
      @(posedge clk); #1;
      cyc++;
      exp_off = f_addr[w] - BASE;
      if (bus.mem_r || bus.mem_w) begin
        strobes++;
        if (bus.mem_addr !== exp_off || bus.mem_c !== f_size[w] || bus.mem_s !== f_sign[w] ||
            bus.mem_w !== f_we[w] || bus.mem_r !== !f_we[w] ||
            (f_we[w] && bus.mem_wdata !== f_wdata[w])) shape_bad = 1'b1;
      end
      if (bus.ack != 2'b00) begin
        flt = model_reject(f_addr[w], f_size[w]);
        obs_fault = bus.fault;
        check({name, " ack"}, 32'(bus.ack), (w == 1) ? 32'd2 : 32'd1);
        check({name, " fault"}, 32'(bus.fault), 32'(flt));
        check({name, " rdata"}, bus.rdata, (flt || f_we[w]) ? 32'h0 : mem_model(exp_off));
        check({name, " latency"}, 32'(cyc - start), flt ? 32'd1 : 32'(2 + WAIT));
        check({name, " strobes"}, 32'(strobes), flt ? 32'd0 : 32'(WAIT + 1));
        check({name, " strobe fields"}, 32'(shape_bad), 32'd0);
        bus.req[w] = 1'b0;
        pending[w] = 1'b0;
        model_last = w[0];
        if (pending == 2'b00) begin
          done = 1'b1;
        end else begin
          w = model_pick(pending);
          start = cyc + 1; strobes = 0; shape_bad = 1'b0;
        end
      end else if (cyc > 100) begin
        checks++; errors++;
        $display("FAIL %s timeout: no ack after %0d cycles, required within %0d", name, cyc, 2 + WAIT);
        bus.req = 2'b00;
        done = 1'b1;
      end
    end
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic        m;
    logic        we;
    logic [1:0]  size;
    logic        sign;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_fault;
  } vec_t;

  vec_t tbl[12];

  initial begin
    logic        obs;
    logic [31:0] a;
    int          acks[4];
    int          n, cyc, ew;
    bit          seen;

    tbl[0]  = '{1'b0, 1'b0, SZ_WORD, 1'b0, 32'h1001_0010, 32'h0,          1'b0};
    tbl[1]  = '{1'b1, 1'b1, SZ_BYTE, 1'b0, 32'h1001_0003, 32'h0000_00A5,  1'b0};
    tbl[2]  = '{1'b0, 1'b0, SZ_WORD, 1'b0, 32'h1001_0002, 32'h0,          1'b1};
    tbl[3]  = '{1'b1, 1'b0, SZ_WORD, 1'b0, 32'h1000_FFFC, 32'h0,          1'b1};
    tbl[4]  = '{1'b0, 1'b1, SZ_WORD, 1'b0, 32'h1001_1000, 32'h1234_5678,  1'b1};
    tbl[5]  = '{1'b0, 1'b0, SZ_WORD, 1'b0, 32'h1001_0FFC, 32'h0,          1'b0};
    tbl[6]  = '{1'b1, 1'b0, SZ_BYTE, 1'b1, 32'h1001_0FFF, 32'h0,          1'b0};
    tbl[7]  = '{1'b0, 1'b0, SZ_HALF, 1'b0, 32'h1001_0005, 32'h0,          1'b1};
    tbl[8]  = '{1'b1, 1'b0, SZ_HALF, 1'b1, 32'h1001_0006, 32'h0,          1'b0};
    tbl[9]  = '{1'b0, 1'b1, SZ_RSVD, 1'b0, 32'h1001_0000, 32'hCAFE_F00D,  1'b1};
    tbl[10] = '{1'b1, 1'b1, SZ_HALF, 1'b0, 32'h1001_0FFE, 32'h0000_BEEF,  1'b0};
    tbl[11] = '{1'b0, 1'b0, SZ_BYTE, 1'b0, 32'h1000_FFFF, 32'h0,          1'b1};

    for (int m = 0; m < 2; m++) begin
      f_we[m] = 1'b0; f_size[m] = SZ_WORD; f_sign[m] = 1'b0;
      f_addr[m] = BASE; f_wdata[m] = 32'h0;
    end
    drive_fields();
    bus.req = 2'b00;
    model_last = 1'b1;

    // Reset state.
    #1 rst = 1'b0;
    #2;
    check("reset ack", 32'(bus.ack), 32'd0);
    check("reset strobes", {30'd0, bus.mem_w, bus.mem_r}, 32'd0);
    check("reset fault", 32'(bus.fault), 32'd0);
    check("reset mem_addr", bus.mem_addr, 32'h0);
    check("reset rdata", bus.rdata, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Directed vector table.
    for (int i = 0; i < 12; i++) begin
      f_we[tbl[i].m] = tbl[i].we;     f_size[tbl[i].m] = tbl[i].size;
      f_sign[tbl[i].m] = tbl[i].sign; f_addr[tbl[i].m] = tbl[i].addr;
      f_wdata[tbl[i].m] = tbl[i].wdata;
      run_txn(tbl[i].m ? 2'b10 : 2'b01, $sformatf("vec%0d", i), obs);
      check($sformatf("vec%0d table fault", i), 32'(obs), 32'(tbl[i].exp_fault));
    end

    // Request held through its ack: a second access follows 3+WAIT later.
    f_we[0] = 1'b0; f_size[0] = SZ_WORD; f_sign[0] = 1'b0; f_addr[0] = BASE + 32'h40;
    drive_fields();
    bus.req = 2'b01;
    n = 0; cyc = 0;
    while (n < 2 && cyc < 60) begin
      @(posedge clk); #1; cyc++;
      if (bus.ack != 2'b00) begin
        check("hold ack", 32'(bus.ack), 32'd1);
        check("hold rdata", bus.rdata, mem_model(32'h40));
        acks[n] = cyc; n++;
      end
    end
    bus.req = 2'b00;
    model_last = 1'b0;
    check("hold ack count", 32'(n), 32'd2);
    check("hold first ack cycle", 32'(acks[0]), 32'(2 + WAIT));
    check("hold ack spacing", 32'(acks[1] - acks[0]), 32'(3 + WAIT));
    @(posedge clk); #1;

    // Reset mid-access: strobes drop at once and no ack is ever produced.
    f_we[0] = 1'b0; f_size[0] = SZ_WORD; f_addr[0] = BASE + 32'h20;
    drive_fields();
    bus.req = 2'b01;
    repeat (2) @(posedge clk);
    #1;
    check("pre-reset mem_r", 32'(bus.mem_r), 32'd1);
    rst = 1'b0;
    #1;
    check("mid-reset strobes", {30'd0, bus.mem_w, bus.mem_r}, 32'd0);
    check("mid-reset ack", 32'(bus.ack), 32'd0);
    check("mid-reset mem_addr", bus.mem_addr, 32'h0);
    bus.req = 2'b00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    model_last = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (bus.ack != 2'b00 || bus.mem_r || bus.mem_w) seen = 1'b1;
    end
    check("post-reset quiet", 32'(seen), 32'd0);

    // Both masters hold requests continuously: four consecutive tie decisions.
    f_we[0] = 1'b0; f_size[0] = SZ_WORD; f_addr[0] = BASE + 32'h100;
    f_we[1] = 1'b1; f_size[1] = SZ_WORD; f_addr[1] = BASE + 32'h200; f_wdata[1] = 32'h5A5A_0001;
    drive_fields();
    bus.req = 2'b11;
    n = 0; cyc = 0;
    while (n < 4 && cyc < 100) begin
      @(posedge clk); #1; cyc++;
      if (bus.ack != 2'b00) begin
        ew = model_pick(2'b11);
        check($sformatf("tie%0d winner", n), 32'(bus.ack), (ew == 1) ? 32'd2 : 32'd1);
        check($sformatf("tie%0d cycle", n), 32'(cyc), 32'((2 + WAIT) + n * (3 + WAIT)));
        model_last = ew[0];
        n++;
      end
    end
    bus.req = 2'b00;
    check("tie ack count", 32'(n), 32'd4);
    @(posedge clk); #1;

    // Normal access after reset.
    f_we[0] = 1'b0; f_size[0] = SZ_WORD; f_addr[0] = BASE + 32'h10;
    run_txn(2'b01, "post-reset", obs);

    // Randomized traffic against the model.
    for (int it = 0; it < 40; it++) begin
      for (int m = 0; m < 2; m++) begin
        f_we[m]    = 1'($urandom_range(0, 1));
        f_sign[m]  = 1'($urandom_range(0, 1));
        f_size[m]  = ($urandom_range(0, 9) == 0) ? SZ_RSVD : 2'($urandom_range(0, 2));
        f_wdata[m] = $urandom;
        case ($urandom_range(0, 9))
          0:       a = BASE + MEMB + 32'($urandom_range(0, 64));
          1:       a = BASE - 32'($urandom_range(1, 64));
          default: a = BASE + 32'($urandom_range(0, 32'h0FFF));
        endcase
        if ($urandom_range(0, 9) < 8) begin
          if (f_size[m] == SZ_WORD) a[1:0] = 2'b00;
          if (f_size[m] == SZ_HALF) a[0] = 1'b0;
        end
        f_addr[m] = a;
      end
      run_txn(2'($urandom_range(1, 3)), $sformatf("rand%0d", it), obs);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter and sequencer for the single data-memory port (the `MEM` block). The CPU data path and a secondary master (boot loader / debug DMA) share one physical memory. The block sits between the masters and `MEM`. It serialises accesses, subtracts the data-segment base, range/alignment-checks each request, and holds the memory strobes for a fixed number of wait cycles before acknowledging.

## Interface
Parameters:
- `BASE_ADDR`, default 32'h1001_0000: byte address mapped to memory offset 0.
- `MEM_BYTES`, default 32'h0000_1000: size of the data memory; offsets at or above this fault.
- `WAIT_CYCLES`, default 0: extra cycles strobes are held, range 0..15.

Ports (clock and reset first):
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req[1:0]`  in  2  per-master request; index 0 is the CPU, index 1 is the loader.
- `we[1:0]`  in  2  per-master write enable.
- `size0`, `size1`  in  2 each  access size: 00 word, 01 half, 10 byte, 11 reserved.
- `sign[1:0]`  in  2  sign-extend loads.
- `addr0`, `addr1`  in  32 each  byte address.
- `wdata0`, `wdata1`  in  32 each  store data.
- `rdata`  out  32  load data (shared); valid only while `ack` is high.
- `ack[1:0]`  out  2  one-cycle completion pulse to the granted master.
- `fault`  out  1  high together with `ack` when the access was rejected.
- `mem_w`, `mem_r`  out  1 each  memory write / read strobes.
- `mem_c`  out  2  memory size code.
- `mem_s`  out  1  memory sign code.
- `mem_addr`  out  32  memory offset (`addr - BASE_ADDR`).
- `mem_wdata`  out  32  memory write data.
- `mem_rdata`  in  32  memory read data; combinational from `MEM`.

## Operation
- Four states: IDLE, ACCESS, DONE, and FAULT.
- **IDLE:** when any `req` is high, pick a winner and latch its `we`, size, sign, offset and wdata into internal registers. The next state is ACCESS, or FAULT if the request is rejected.
- **Reject conditions:**
  - offset ≥ `MEM_BYTES`, unsigned, which includes any `addr` below `BASE_ADDR` because the subtraction wraps;
  - size 11;
  - word access with `addr[1:0]` ≠ 0;
  - half access with `addr[0]` = 1.
- **ACCESS:** drive `mem_c`, `mem_s`, `mem_addr` and `mem_wdata` from the latched registers. Assert `mem_r` (load) or `mem_w` (store) for exactly `WAIT_CYCLES+1` cycles, counted by a 4-bit down-counter. On the last ACCESS cycle, register `mem_rdata`, then go to DONE.
- **DONE:** assert `ack[winner]` for one cycle. `rdata` carries the registered load data; it is 0 for stores. Then return to IDLE.
- **FAULT:** assert `ack[winner]` and `fault` for one cycle with `rdata` = 0; no memory strobe. Then return to IDLE.
- Arbitration is decided only in IDLE. A grant is never preempted.
- A request arriving while the port is busy waits; the master keeps `req` and its fields stable until its `ack`.
- Outside ACCESS, `mem_w` and `mem_r` are 0; `mem_addr`, `mem_c`, `mem_s` and `mem_wdata` hold their latched values.

## Timing
- The request is first seen in IDLE at cycle 0.
- Normal access: `ack` is high in cycle 2+`WAIT_CYCLES`.
- Faulted access: `ack` is high in cycle 1.
- A master must drop `req` on the edge that ends its `ack` cycle. A `req` still high in the following IDLE cycle starts a new transaction.
- Back-to-back throughput is one access per 3+`WAIT_CYCLES` cycles.
- Reset (asynchronous, any state) forces:
  - state IDLE, counter 0;
  - all outputs 0;
  - the round-robin pointer to favour master 0.
- An in-flight access is abandoned without `ack`. A partial write may have been issued to memory; masters must reissue it.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin arbitration. A 1-bit last-grant pointer is updated on every grant. On simultaneous requests, the master not granted last wins.
- Not defined: fixed priority, with master 0 (CPU) always winning a tie. The pointer register is not built.

## Structure
- Shared package `mem_arb_pkg` holds:
  - the state enum (IDLE, ACCESS, DONE, FAULT);
  - size code constants (`SZ_WORD`=00, `SZ_HALF`=01, `SZ_BYTE`=10);
  - the default `BASE_ADDR` constant.
- One sub-module, `mem_arb_pick`: combinational winner selection from `req` and the pointer. It contains the `MEM_ARB_RR_EN` logic.
- The top module holds the FSM, wait counter, field latches, range/alignment check and read-data register.

## Test plan
- CPU load word, addr 32'h1001_0010, `WAIT_CYCLES`=0, memory returns 32'hDEAD_BEEF:
  - `mem_r`=1 with `mem_addr`=32'h10 in cycle 1;
  - `ack[0]`=1 and `rdata`=32'hDEAD_BEEF in cycle 2.
- Loader store byte to 32'h1001_0003 with data 32'h0000_00A5, `WAIT_CYCLES`=3:
  - `mem_w` high for exactly 4 cycles with `mem_c`=10;
  - `ack[1]` in cycle 5.
- Both `req` high in the same cycle, repeated, with `MEM_ARB_RR_EN`:
  - grants alternate 0, 1, 0, 1;
  - without the macro, master 0 wins each time.
- Fault cases, each giving `ack`+`fault` in cycle 1, no strobe, `rdata`=0:
  - word load at 32'h1001_0002;
  - any access at 32'h1000_FFFC;
  - any access at `BASE_ADDR`+`MEM_BYTES`.
- Reset sequence:
  - assert `rst`=0 mid-ACCESS with `WAIT_CYCLES`=5: strobes drop immediately and no `ack` occurs;
  - after release, a new request completes normally.
- Hold `req[0]` high through its `ack`: a second identical access starts, and its `ack` arrives 3+`WAIT_CYCLES` cycles after the first.
